// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL sets both flops on reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled 8N1 frames into a one-entry holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with a live rx_parity_err flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 rxclk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_over_run,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 sample_pt;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (rxclk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  assign sample_pt = (tick == TICK_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_mis;
`else
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge rxclk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      tick          <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_empty      <= 1'b1;
      rx_over_run   <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      // Unload first so that a commit in the same edge overrides it.
      if (uld_rx_data) begin
        rx_empty    <= 1'b1;
        rx_over_run <= 1'b0;
      end

      if (!rx_enable) begin
        state   <= ST_IDLE;
        tick    <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state <= ST_START;
              tick  <= '0;
            end
          end

          ST_START: begin
            if (tick == TICK_HALF) begin
              if (rx_s) begin
                state <= ST_IDLE;
              end else begin
                state   <= ST_DATA;
                tick    <= '0;
                bit_cnt <= '0;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          ST_DATA: begin
            if (sample_pt) begin
              tick    <= '0;
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (sample_pt) begin
              tick    <= '0;
              par_mis <= rx_s ^ (^shift);
              state   <= ST_STOP;
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
`endif

          ST_STOP: begin
            if (sample_pt) begin
              tick         <= '0;
              state        <= ST_IDLE;
              rx_data      <= shift;
              rx_empty     <= 1'b0;
              rx_frame_err <= !rx_s;
              rx_over_run  <= !rx_empty && !uld_rx_data;
`ifdef UART_RX_PARITY_EN
              rx_parity_err <= par_mis;
`endif
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames against a frame-level holding-register model.
module tb_uart_rx;

  localparam int unsigned OS = 16;
  localparam int unsigned DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          rxclk;
  logic          reset;
  logic          rx_enable;
  logic          rx_in;
  logic          uld_rx_data;
  logic [DW-1:0] rx_data;
  logic          rx_empty;
  logic          rx_over_run;
  logic          rx_frame_err;
  logic          rx_parity_err;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DW)) dut (
    .rxclk         (rxclk),
    .reset         (reset),
    .rx_enable     (rx_enable),
    .rx_in         (rx_in),
    .uld_rx_data   (uld_rx_data),
    .rx_data       (rx_data),
    .rx_empty      (rx_empty),
    .rx_over_run   (rx_over_run),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected holding-register contents
  logic [DW-1:0] m_data;
  logic          m_empty;
  logic          m_ovr;
  logic          m_ferr;
  logic          m_perr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_data"},  32'(rx_data),       32'(m_data));
    check_val({tag, "_empty"}, 32'(rx_empty),      32'(m_empty));
    check_val({tag, "_ovr"},   32'(rx_over_run),   32'(m_ovr));
    check_val({tag, "_ferr"},  32'(rx_frame_err),  32'(m_ferr));
    check_val({tag, "_perr"},  32'(rx_parity_err), 32'(m_perr));
  endtask

  task automatic next_cycle();
    @(posedge rxclk);
    #1;
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_empty = 1'b1;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (OS) next_cycle();
  endtask

  // Serial frame; rx_empty must still hold its old value 154 cycles after the start edge
  // is driven (2 sync + 152) and show the commit one cycle later.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input logic par_bit,
                            input logic uld_c, input int gap, input string tag);
    logic pre_empty;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par_bit);
    rx_in = stop_bit;
    repeat (OS / 2 + 2) next_cycle();
    if (uld_c) uld_rx_data = 1'b1;
    @(negedge rxclk);
    check_val({tag, "_pre_empty"}, 32'(rx_empty), 32'(m_empty));
    pre_empty = m_empty;
    next_cycle();
    uld_rx_data = 1'b0;
    m_data  = d;
    m_empty = 1'b0;
    m_ovr   = !pre_empty && !uld_c;
    m_ferr  = !stop_bit;
    m_perr  = PAR_EN && (par_bit != ^d);
    @(negedge rxclk);
    check_state({tag, "_post"});
    repeat (OS - OS / 2 - 3) next_cycle();
    rx_in = 1'b1;
    repeat (gap) next_cycle();
  endtask

  task automatic unload(input string tag);
    uld_rx_data = 1'b1;
    next_cycle();
    uld_rx_data = 1'b0;
    m_empty = 1'b1;
    m_ovr   = 1'b0;
    @(negedge rxclk);
    check_state(tag);
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time %0t expected bench completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d;
    logic          stop_b;
    logic          par_b;
    logic          uc;
    int            gap;

    rx_in       = 1'b1;
    rx_enable   = 1'b1;
    uld_rx_data = 1'b0;
    reset       = 1'b0;
    model_reset();
    repeat (3) next_cycle();
    @(negedge rxclk);
    check_state("reset");
    next_cycle();
    reset = 1'b1;
    repeat (5) next_cycle();

    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 20, "a5");
    unload("unl_a5");

    send_frame(8'h3C, 1'b1, ^8'h3C, 1'b0, 20, "3c");
    send_frame(8'h81, 1'b1, ^8'h81, 1'b0, 20, "81_ovr");
    unload("unl_ovr");

    send_frame(8'h55, 1'b0, ^8'h55, 1'b0, 30, "55_ferr");
    unload("unl_ferr");

    // Short low glitch must be rejected as a false start
    rx_in = 1'b0;
    repeat (4) next_cycle();
    rx_in = 1'b1;
    repeat (30) next_cycle();
    @(negedge rxclk);
    check_state("glitch");
    next_cycle();
    send_frame(8'h0F, 1'b1, ^8'h0F, 1'b0, 20, "0f");

    // Abort a frame by dropping enable in data bit 3
    d = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_in = d[3];
    repeat (OS / 2) next_cycle();
    rx_enable = 1'b0;
    rx_in     = 1'b1;
    repeat (5) next_cycle();
    rx_enable = 1'b1;
    repeat (30) next_cycle();
    @(negedge rxclk);
    check_state("en_abort");
    next_cycle();
    send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0, 20, "c3");
    unload("unl_c3");

    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 20, "par_ok");
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 20, "par_bad");

    send_frame(8'hE7, 1'b1, ^8'hE7, 1'b1, 20, "uld_commit");

    send_frame(8'h12, 1'b1, ^8'h12, 1'b0, 0, "b2b_a");
    send_frame(8'h34, 1'b1, ^8'h34, 1'b0, 20, "b2b_b");

    for (int n = 0; n < 30; n++) begin
      d      = DW'($urandom);
      stop_b = ($urandom_range(5) != 0);
      par_b  = ($urandom_range(3) == 0) ? ~(^d) : ^d;
      uc     = ($urandom_range(4) == 0);
      gap    = (stop_b && $urandom_range(3) == 0) ? 0 : int'($urandom_range(40, 20));
      if ($urandom_range(1) == 1) unload("rnd_unl");
      send_frame(d, stop_b, par_b, uc, gap, "rnd");
    end

    // Reset in the middle of a frame discards it and restores reset values
    rx_in = 1'b0;
    repeat (40) next_cycle();
    reset = 1'b0;
    rx_in = 1'b1;
    next_cycle();
    reset = 1'b1;
    model_reset();
    @(negedge rxclk);
    check_state("mid_reset");
    next_cycle();
    repeat (30) next_cycle();
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0, 20, "post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the simple UART: recovers 8N1 frames (optionally 8E1) from the serial line `rx_in` using 16x oversampling on `rxclk`. It presents each byte in a one-entry holding register with an empty flag and overrun/framing status. It pairs with the existing transmitter across the serial link and feeds the host-side unload logic.

## Interface
Parameters:
- `OVERSAMPLE`, 16: `rxclk` cycles per bit. Even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, sent LSB first.

Ports:
- `rxclk`  in  1  the only clock; 16x bit rate.
- `reset`  in  1  synchronous, active-low reset, sampled on `rxclk` rising edge.
- `rx_enable`  in  1  receiver enable; low aborts any frame in progress.
- `rx_in`  in  1  asynchronous serial input; idles high.
- `uld_rx_data`  in  1  unload strobe; one-cycle pulse consumes `rx_data`.
- `rx_data`  out  DATA_BITS  last received byte.
- `rx_empty`  out  1  holding register empty.
- `rx_over_run`  out  1  a frame completed while `rx_empty` was 0.
- `rx_frame_err`  out  1  last frame's stop bit sampled low.
- `rx_parity_err`  out  1  last frame's parity mismatched.

## Operation
- `rx_in` passes through a 2-flop synchronizer, reset value 1. All FSM logic uses the synchronized value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START: `rx_s`==0 and `rx_enable`. Clear the tick counter.
  - START: at tick `OVERSAMPLE/2-1`, sample `rx_s`. If 1, it is a false start: go to IDLE. If 0, go to DATA and clear the tick counter and bit counter.
  - DATA: every `OVERSAMPLE` ticks, shift `rx_s` into the shift register (LSB first). After bit `DATA_BITS-1`, go to PARITY (macro defined) or STOP.
  - PARITY: sample once after `OVERSAMPLE` ticks and compare with the even parity of the data, then go to STOP.
  - STOP: sample after `OVERSAMPLE` ticks. In the same edge, go to IDLE and commit the frame.
- Commit, all in one edge:
  - `rx_data` ← shift register.
  - `rx_empty` ← 0.
  - `rx_frame_err` ← !stop sample.
  - `rx_parity_err` ← mismatch.
  - If `rx_empty` was 0 and `uld_rx_data` is not asserted in the same cycle, set `rx_over_run` ← 1. The new data still overwrites the old.
- A framing error still commits the data.
- `uld_rx_data` sets `rx_empty` ← 1 and clears `rx_over_run`. `rx_data` holds its value. An unload while empty has no effect.
- Unload and commit in the same cycle: the commit wins. Result is `rx_empty`=0 and `rx_over_run`=0.
- `rx_enable` low: the FSM goes to IDLE and the counters clear on the next edge. `rx_data`, `rx_empty` and the error flags are untouched.
- Tick counter is `$clog2(OVERSAMPLE)` bits and wraps to 0 at each sample point. Bit counter is `$clog2(DATA_BITS+1)` bits.

## Timing
- Reset values:
  - `rx_data`=0, `rx_empty`=1.
  - `rx_over_run`=0, `rx_frame_err`=0, `rx_parity_err`=0.
  - FSM in IDLE, synchronizer flops=1.
  - A reset mid-frame discards the frame.
- Synchronizer latency: 2 cycles from `rx_in` to `rx_s`.
- Define T as the first cycle `rx_s`=0 in IDLE. Sample points:
  - Start bit: T+`OVERSAMPLE/2`.
  - Data bit i: T+`OVERSAMPLE/2`+`OVERSAMPLE`·(i+1).
  - Stop bit, 8N1 at defaults: T+152.
- Commit and all output updates at defaults:
  - Outputs update on the edge after the stop sample: `rx_empty` falls at T+153 (8N1).
  - With parity: T+169.
- Back-to-back frames: a start edge seen on the cycle after commit is accepted.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists.
  - Frames are 8E1.
  - `rx_parity_err` is live.
- Not defined:
  - No PARITY state; frames are 8N1.
  - `rx_parity_err` is tied 0.
  - Port list is unchanged.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - default constants `UART_OVERSAMPLE` and `UART_DATA_BITS`.
- One sub-module: `uart_sync2`, the 2-flop synchronizer with a reset value parameter. Reused by other async inputs.

## Test plan
- 8N1 frame carrying 0xA5, 16 cycles/bit → `rx_data`=0xA5, `rx_empty` 1→0 at T+153, all error flags 0.
- 0x3C received, not unloaded, then 0x81 received → `rx_data`=0x81, `rx_over_run`=1. A `uld_rx_data` pulse then gives `rx_empty`=1, `rx_over_run`=0.
- 0x55 frame with stop bit driven low → `rx_data`=0x55, `rx_frame_err`=1, `rx_empty`=0.
- 4-cycle low glitch on an idle line → false start, FSM back in IDLE, `rx_empty` stays 1. A following 0x0F frame is received correctly.
- `rx_enable` dropped during data bit 3, then 0xC3 sent with enable high → only 0xC3 committed. `reset` low mid-frame → all outputs at reset values on the next edge.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → `rx_parity_err`=0. With parity bit 0 → `rx_parity_err`=1.
